// File: rtl/ysyx_24110015_mem_responder_pkg.sv
// Shared definitions for the handshaked memory responder: FSM encoding,
// response error codes and the default memory-map constants.
package ysyx_24110015_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } rsp_state_e;

    // Memory map defaults: the array starts at the reset PC region
    localparam logic [31:0] MEM_ADDR_BASE   = 32'h8000_0000;
    localparam int          MEM_DEPTH_WORDS = 1024;
    localparam int          MEM_LATENCY     = 2;

    localparam logic RSP_ERR_NONE = 1'b0;
    localparam logic RSP_ERR_OOR  = 1'b1;

endpackage

// File: rtl/ysyx_24110015_mem_responder_sram_bank.sv
// Word-organised synchronous array with byte write enables and a read
// register that captures the pre-write word on the accepting edge.
module ysyx_24110015_sram_bank #(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_i,
    input  logic             rd_i,
    input  logic             wr_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wmask_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Byte-lane write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response word capture: zero for stores and out-of-range accesses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= 32'd0;
        end else if (cap_i) begin
            rdata_q <= rd_i ? mem_q[idx_i] : 32'd0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_24110015_mem_responder.sv
// Single-outstanding load/store responder with a fixed response latency,
// byte-masked stores and an out-of-range error flag.
module ysyx_24110015_mem_responder
    import ysyx_24110015_mem_responder_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = MEM_ADDR_BASE,
    parameter int          DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter int          LATENCY     = MEM_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    rsp_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      offset_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic             req_hs_s;
    logic             rsp_hs_s;
    logic             unused_s;

    // Full-width subtraction so addresses below the base wrap to huge offsets
    assign offset_s   = req_addr - ADDR_BASE;
    assign in_range_s = (offset_s[31:IDX_W+2] == {(30-IDX_W){1'b0}});
    assign idx_s      = offset_s[IDX_W+1:2];
    assign unused_s   = ^offset_s[1:0];
    assign req_hs_s   = req_valid & req_ready;
    assign rsp_hs_s   = rsp_valid & rsp_ready;

    // State, latency counter and error flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state, counter and error capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_hs_s) begin
                    err_d = in_range_s ? RSP_ERR_NONE : RSP_ERR_OOR;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_CNT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_hs_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Handshake outputs decoded from state; ready is held low during reset
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = rst;
            ST_RESP: rsp_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    ysyx_24110015_sram_bank #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .cap_i   (req_hs_s),
        .rd_i    (~req_wen & in_range_s),
        .wr_i    (req_hs_s & req_wen & in_range_s),
        .idx_i   (idx_s),
        .wdata_i (req_wdata),
        .wmask_i (req_wmask),
        .rdata_o (rsp_rdata)
    );

    assign rsp_err = err_q;

endmodule
